// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_pkg
// Description : Command opcodes and read-FSM encoding used by spi_ram and
//               the SPI slave front end that feeds it.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Opcode field din[9:8]
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // Read sequencer: no address / address held / one-cycle fetch
    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_ARMED = 2'b01,
        RD_FETCH = 2'b10
    } rd_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram_array
// Description : Single-clock byte storage, one synchronous write port and
//               one registered read port. Contents are never reset.
// Ports       : clk            - clock
//               we/waddr/wdata - write port
//               re/raddr       - read request, data appears on rdata after
//                                the rising edge with re=1
//               rdata          - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : spi_ram_array
`default_nettype wire

// File: rtl/spi_ram.sv
`default_nettype none
// ============================================================================
// Module      : spi_ram
// Description : Command-driven RAM behind an SPI slave. Decodes 10-bit
//               command words, keeps auto-incrementing write/read pointers,
//               runs the read sequencer and flags out-of-order commands.
// Ports       : clk, rst_n (async, active-low)
//               din[9:0]  - {opcode, payload}, qualified by rx_valid
//               tx_data   - read data, held between reads
//               tx_valid  - one pulse per accepted RD_DATA
//               cmd_err   - one pulse per out-of-sequence data command
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,   // must equal 2**ADDR_SIZE
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] payload_addr;

    rd_state_t            state;
    rd_state_t            state_next;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic                 wr_armed;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] rd_addr_post;
    logic                 ram_we;
    logic                 ram_re;
    logic                 err_next;
    logic [7:0]           ram_rdata;
    logic [7:0]           tx_hold;

    assign opcode       = din[9:8];
    assign payload      = din[7:0];
    assign payload_addr = ADDR_SIZE'(payload);

    // Read pointer as it stands once any in-flight fetch has retired. A new
    // RD_DATA landing in the fetch cycle therefore reads the next word, and
    // wrap-around falls out of the ADDR_SIZE-bit arithmetic.
    assign rd_addr_post = (state == RD_FETCH) ? rd_addr + ADDR_SIZE'(1) : rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        err_next   = 1'b0;
        if (state == RD_FETCH) begin
            state_next = RD_ARMED;
        end
        if (rx_valid) begin
            case (opcode)
                WR_DATA: begin
                    if (wr_armed) begin
                        ram_we = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                RD_ADDR: begin
                    state_next = RD_ARMED;
                end
                RD_DATA: begin
                    if (state == RD_IDLE) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = RD_FETCH;
                        ram_re     = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            wr_armed <= 1'b0;
            rd_addr  <= '0;
            cmd_err  <= 1'b0;
            tx_hold  <= 8'h00;
        end else begin
            cmd_err <= err_next;
            if (rx_valid && opcode == WR_ADDR) begin
                wr_addr  <= payload_addr;
                wr_armed <= 1'b1;
            end else if (ram_we) begin
                wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
            if (rx_valid && opcode == RD_ADDR) begin
                rd_addr <= payload_addr;
            end else begin
                rd_addr <= rd_addr_post;
            end
            if (state == RD_FETCH) begin
                tx_hold <= ram_rdata;
            end
        end
    end

    // The array's read register has no reset, so tx_data is steered from
    // it only during the fetch cycle and otherwise from a resettable copy.
    // Reset drops the FSM to RD_IDLE, which clears both outputs at once.
    assign tx_valid = (state == RD_FETCH);
    assign tx_data  = (state == RD_FETCH) ? ram_rdata : tx_hold;

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (payload),
        .re    (ram_re),
        .raddr (rd_addr_post),
        .rdata (ram_rdata)
    );

endmodule : spi_ram
`default_nettype wire
